// File: rtl/lossless_dequant.sv
// Bitstream decoder and dequantiser that writes 8x8 pre-IDCT blocks to SRAM in row-major order.
// Optional build macro LOSSLESS_DEQUANT_SAT_EN clamps each dequantised value to [-2048, 2047].
module lossless_dequant #(
    parameter logic [17:0] BITSTREAM_BASE = 18'd0,
    parameter logic [17:0] PRE_IDCT_BASE  = 18'd76800,
    parameter int          NUM_BLOCKS     = 2400,
    parameter int          BLOCKS_PER_ROW = 40
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        quant_sel,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done
);
    // state    | meaning
    // IDLE     | waiting for Enable
    // FILL     | loading the first two bitstream words
    // DECODE   | one code per cycle while >= 11 bits are buffered
    // REFILL   | fetching one bitstream word
    // WRITE    | 64 row-major writes of the block buffer
    // NEXT     | advance block index and clear the block
    // DONE     | one-cycle Done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_DECODE, S_REFILL, S_WRITE, S_NEXT, S_DONE
    } state_t;

    localparam int BLK_W = $clog2(NUM_BLOCKS + 1);
    localparam int COL_W = $clog2(BLOCKS_PER_ROW + 1);

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t             state_q, state_d;
    logic [17:0]        addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               we_n_q, we_n_d;
    logic               done_q, done_d;
    logic [17:0]        fetch_addr_q, fetch_addr_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0]         fill_req_q, fill_req_d;
    logic [31:0]        buf_q, buf_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [6:0]         k_q, k_d;
    logic [6:0]         widx_q, widx_d;
    logic               qsel_q, qsel_d;
    logic [BLK_W-1:0]   blk_left_q, blk_left_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [17:0]        row_base_q, row_base_d;
    logic [63:0]        nz_q, nz_d;
    logic [15:0]        coef_mem_q [64];

    logic               coef_we;
    logic [10:0]        top;
    logic [5:0]         pos_k;
    logic [3:0]         diag;
    logic [2:0]         sh;
    logic [15:0]        cext;
    logic [15:0]        deq_val;
    logic [3:0]         run_n;
    logic [6:0]         k_sum;
    logic [6:0]         k_run;
    logic [5:0]         len;
    logic [5:0]         wr_pos;
    logic [17:0]        wr_addr;
    logic [15:0]        wr_data;
`ifdef LOSSLESS_DEQUANT_SAT_EN
    logic [23:0]        shifted;
`endif

    assign top   = buf_q[31:21];
    assign pos_k = ZZ[k_q[5:0]];
    assign diag  = {1'b0, pos_k[5:3]} + {1'b0, pos_k[2:0]};

    always_comb begin
        unique case (diag)
            4'd0:       sh = 3'd3;
            4'd1:       sh = 3'd2;
            4'd2, 4'd3: sh = 3'd3;
            4'd4, 4'd5: sh = 3'd4;
            4'd6, 4'd7: sh = 3'd5;
            default:    sh = 3'd6;
        endcase
        if (qsel_q && (diag != 4'd0)) begin
            sh = sh - 3'd1;
        end
    end

    always_comb begin
        unique case (top[10:9])
            2'b00:   cext = {{13{top[8]}}, top[8:6]};
            2'b01:   cext = {{10{top[8]}}, top[8:3]};
            default: cext = {{7{top[8]}}, top[8:0]};
        endcase
`ifdef LOSSLESS_DEQUANT_SAT_EN
        shifted = {{8{cext[15]}}, cext} << sh;
        if ($signed(shifted) > 24'sd2047) begin
            deq_val = 16'd2047;
        end else if ($signed(shifted) < -24'sd2048) begin
            deq_val = 16'hF800;
        end else begin
            deq_val = shifted[15:0];
        end
`else
        deq_val = cext << sh;
`endif
    end

    // Zero runs that would cross the end of the block are truncated at 64.
    assign run_n = (top[7:5] == 3'd0) ? 4'd8 : {1'b0, top[7:5]};
    assign k_sum = k_q + {3'b000, run_n};
    assign k_run = (k_sum > 7'd64) ? 7'd64 : k_sum;

    assign wr_pos  = widx_q[5:0];
    assign wr_data = nz_q[wr_pos] ? coef_mem_q[wr_pos] : 16'h0000;
    assign wr_addr = row_base_q + 18'({col_q, 3'b000})
                   + (18'(wr_pos[5:3]) << 8) + (18'(wr_pos[5:3]) << 6)
                   + 18'(wr_pos[2:0]);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_n_d       = 1'b1;
        done_d       = 1'b0;
        fetch_addr_d = fetch_addr_q;
        pend_d       = {pend_q[0], 1'b0};
        fill_req_d   = fill_req_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        widx_d       = widx_q;
        qsel_d       = qsel_q;
        blk_left_d   = blk_left_q;
        col_d        = col_q;
        row_base_d   = row_base_q;
        nz_d         = nz_q;
        coef_we      = 1'b0;
        len          = 6'd0;

        if (pend_q[1]) begin
            buf_d = buf_q | ({SRAM_read_data, 16'h0000} >> cnt_q);
            cnt_d = cnt_q + 6'd16;
        end

        unique case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    qsel_d       = quant_sel;
                    blk_left_d   = BLK_W'(NUM_BLOCKS);
                    col_d        = '0;
                    row_base_d   = PRE_IDCT_BASE;
                    k_d          = 7'd0;
                    widx_d       = 7'd0;
                    nz_d         = 64'd0;
                    buf_d        = 32'd0;
                    cnt_d        = 6'd0;
                    addr_d       = BITSTREAM_BASE;
                    fetch_addr_d = BITSTREAM_BASE + 18'd1;
                    pend_d[0]    = 1'b1;
                    fill_req_d   = 2'd1;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_req_q != 2'd2) begin
                    addr_d       = fetch_addr_q;
                    fetch_addr_d = fetch_addr_q + 18'd1;
                    pend_d[0]    = 1'b1;
                    fill_req_d   = fill_req_q + 2'd1;
                end
                if (cnt_q == 6'd32) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (k_q == 7'd64) begin
                    we_n_d  = 1'b0;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    widx_d  = widx_q + 7'd1;
                    state_d = S_WRITE;
                end else if (cnt_q < 6'd11) begin
                    addr_d       = fetch_addr_q;
                    fetch_addr_d = fetch_addr_q + 18'd1;
                    pend_d[0]    = 1'b1;
                    state_d      = S_REFILL;
                end else begin
                    if (top[10:9] != 2'b11) begin
                        coef_we     = 1'b1;
                        nz_d[pos_k] = 1'b1;
                        k_d         = k_q + 7'd1;
                        len         = (top[10:9] == 2'b00) ? 6'd5 :
                                      (top[10:9] == 2'b01) ? 6'd8 : 6'd11;
                    end else if (!top[8]) begin
                        k_d = k_run;
                        len = 6'd6;
                    end else begin
                        k_d = 7'd64;
                        len = 6'd3;
                    end
                    buf_d = buf_q << len;
                    cnt_d = cnt_q - len;
                end
            end
            S_REFILL: begin
                if (pend_q[1]) begin
                    state_d = S_DECODE;
                end
            end
            S_WRITE: begin
                if (widx_q == 7'd64) begin
                    state_d = S_NEXT;
                end else begin
                    we_n_d  = 1'b0;
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    widx_d  = widx_q + 7'd1;
                end
            end
            S_NEXT: begin
                nz_d       = 64'd0;
                k_d        = 7'd0;
                widx_d     = 7'd0;
                blk_left_d = blk_left_q - BLK_W'(1);
                if (col_q == COL_W'(BLOCKS_PER_ROW - 1)) begin
                    col_d      = '0;
                    row_base_d = row_base_q + 18'd2560;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                if (blk_left_q == BLK_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            addr_q       <= 18'd0;
            wdata_q      <= 16'd0;
            we_n_q       <= 1'b1;
            done_q       <= 1'b0;
            fetch_addr_q <= 18'd0;
            pend_q       <= 2'd0;
            fill_req_q   <= 2'd0;
            buf_q        <= 32'd0;
            cnt_q        <= 6'd0;
            k_q          <= 7'd0;
            widx_q       <= 7'd0;
            qsel_q       <= 1'b0;
            blk_left_q   <= '0;
            col_q        <= '0;
            row_base_q   <= 18'd0;
            nz_q         <= 64'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_n_q       <= we_n_d;
            done_q       <= done_d;
            fetch_addr_q <= fetch_addr_d;
            pend_q       <= pend_d;
            fill_req_q   <= fill_req_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            widx_q       <= widx_d;
            qsel_q       <= qsel_d;
            blk_left_q   <= blk_left_d;
            col_q        <= col_d;
            row_base_q   <= row_base_d;
            nz_q         <= nz_d;
        end
    end

    // Stale entries are masked by nz_q, so the coefficient store needs no reset.
    always_ff @(posedge Clock) begin
        if (coef_we) begin
            coef_mem_q[pos_k] <= deq_val;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Done            = done_q;
endmodule
